// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
// Round-robin arbiter sharing one registered-read sprite ROM among N_REQ
// draw engines. One read issued per clock; the palette index coming back
// from the ROM is tagged with the ID of the requester that issued it.
module sprite_rom_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 5,
    parameter int ID_W   = 2
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    hold,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    output logic [N_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [DATA_W-1:0]       rom_data,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [DATA_W-1:0]       rsp_data
);

    logic [ID_W-1:0]   r_ptr;
    logic              r_iss_valid;
    logic [ID_W-1:0]   r_iss_id;
    logic [N_REQ-1:0]  r_gnt;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;

    logic              w_hi_found;
    logic [ID_W-1:0]   w_hi_idx;
    logic              w_lo_found;
    logic [ID_W-1:0]   w_lo_idx;
    logic [ID_W-1:0]   w_pick;
    logic [ID_W-1:0]   w_ptr_next;
    logic              w_grant;
    logic [N_REQ-1:0]  w_gnt_next;
    logic [ADDR_W-1:0] w_addr;

    // Pick the first requester at or after r_ptr; if none, wrap to the lowest set bit.
    always_comb begin
        // NOTE: every signal gets a default before any conditional write so no latch is inferred.
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
        // Descending scan: the last hit overwrites, leaving the lowest index.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = ID_W'(k);
                if (ID_W'(k) >= r_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = ID_W'(k);
                end
            end
        end
        w_pick  = w_hi_found ? w_hi_idx : w_lo_idx;
        w_grant = !hold && w_lo_found;
    end

    // Derive the grant vector, selected address and next pointer from the pick.
    always_comb begin
        w_addr = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_pick == ID_W'(k)) begin
                w_addr = addr[k*ADDR_W +: ADDR_W];
            end
        end
        w_gnt_next = N_REQ'(1) << w_pick;
        // Wrap at N_REQ, which need not be a power of two.
        w_ptr_next = (w_pick == ID_W'(N_REQ - 1)) ? '0 : w_pick + ID_W'(1);
    end

    // Issue stage: register the grant, ROM address and owner; advance the pointer.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_gnt       <= '0;
            r_rom_addr  <= '0;
            r_iss_valid <= 1'b0;
            r_iss_id    <= '0;
            r_ptr       <= '0;
        end else if (w_grant) begin
            // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
            r_gnt       <= w_gnt_next;
            r_rom_addr  <= w_addr;
            r_iss_valid <= 1'b1;
            r_iss_id    <= w_pick;
            r_ptr       <= w_ptr_next;
        end else begin
            // Address and pointer hold so an idle ROM sees a stable input.
            r_gnt       <= '0;
            r_iss_valid <= 1'b0;
        end
    end

    // Response stage: follows the issue stage by one edge, matching ROM latency.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
        end else begin
            r_rsp_valid <= r_iss_valid;
            r_rsp_id    <= r_iss_id;
        end
    end

    assign gnt       = r_gnt;
    assign rom_addr  = r_rom_addr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    // ROM output is already registered; consumers qualify it with rsp_valid.
    assign rsp_data  = rom_data;

endmodule
